trig_delay_pulse: RTL and testbench

Consumes the single-cycle trigger pulse produced by the flag clock-domain crosser in the destination domain and turns it into a delayed output pulse of programmable width, followed by a programmable hold-off dead time. Tracks accepted and missed triggers for status readout. Sits between the CDC stage and the digitizer/averager acquisition start logic.

---
 rtl/trig_delay_pulse.sv | 143 ++++++++++++++
 tb/tb_trig_delay_pulse.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_delay_pulse.sv
// Turns an accepted single-cycle trigger into a delayed pulse of programmable
// width, followed by a hold-off dead time, and counts accepted and missed triggers.
module trig_delay_pulse #(
  parameter int CNT_W  = 32,
  parameter int MISS_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic              trig,
  input  logic [CNT_W-1:0]  delay,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic              clear,
  output logic              pulse_out,
  output logic              busy,
  output logic [31:0]       trig_count,
  output logic [MISS_W-1:0] miss_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_PULSE   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  width_sh_q, width_sh_d;
  logic [CNT_W-1:0]  hold_sh_q, hold_sh_d;
  logic              pulse_q, pulse_d;
  logic              busy_q, busy_d;
  logic [31:0]       trig_cnt_q, trig_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             accept;
  logic             miss;
  logic [CNT_W-1:0] width_norm;

  // Handshake: trig is a one-cycle strobe with no back-pressure. It is taken
  // only when the FSM is idle and the registered busy has dropped; any other
  // enabled trig is rejected and counted as a miss.
  assign accept     = trig && enable && (state_q == S_IDLE) && !busy_q;
  assign miss       = trig && enable && !accept;
  assign width_norm = (width == '0) ? CNT_W'(1) : width;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_sh_d = width_sh_q;
    hold_sh_d  = hold_sh_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          width_sh_d = width_norm;
          hold_sh_d  = holdoff;
          if (delay != '0) begin
            state_d = S_DELAY;
            cnt_d   = delay - CNT_W'(1);
          end else begin
            state_d = S_PULSE;
            cnt_d   = width_norm - CNT_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = width_sh_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          if (hold_sh_q != '0) begin
            state_d = S_HOLDOFF;
            cnt_d   = hold_sh_q - CNT_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    // Outputs trail the FSM by one edge, so busy also covers the edge on
    // which the FSM returns to idle.
    pulse_d = enable && (state_q == S_PULSE);
    busy_d  = enable && (state_q != S_IDLE);

    if (clear)       trig_cnt_d = '0;
    else if (accept) trig_cnt_d = trig_cnt_q + 32'd1;
    else             trig_cnt_d = trig_cnt_q;

    if (clear)                           miss_cnt_d = '0;
    else if (miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + MISS_W'(1);
    else                                 miss_cnt_d = miss_cnt_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      width_sh_q <= '0;
      hold_sh_q  <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      width_sh_q <= width_sh_d;
      hold_sh_q  <= hold_sh_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      trig_cnt_q <= trig_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign busy       = busy_q;
  assign trig_count = trig_cnt_q;
  assign miss_count = miss_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_trig_delay_pulse.sv
// Bench for trig_delay_pulse: table vectors, directed corner sequences and
// randomized traffic against a window-arithmetic reference model.
module tb_trig_delay_pulse;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic        trig;
  logic [31:0] delay;
  logic [31:0] width;
  logic [31:0] holdoff;
  logic        clear;
  logic        pulse_out;
  logic        busy;
  logic [31:0] trig_count;
  logic [15:0] miss_count;
  logic [1:0]  state_dbg;

  trig_delay_pulse #(.CNT_W(32), .MISS_W(16)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .trig       (trig),
    .delay      (delay),
    .width      (width),
    .holdoff    (holdoff),
    .clear      (clear),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .trig_count (trig_count),
    .miss_count (miss_count),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  longint edge_n = 0;

  // Reference model: an accepted trigger at edge c0 owns the edge windows
  // pulse [c0+D+1, c0+D+W] and busy [c0+1, c0+D+W+H].
  bit          m_active;
  longint      m_c0, m_d, m_w, m_h;
  logic [31:0] mdl_tc;
  logic [15:0] mdl_mc;
  logic [49:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_c0 = 0; m_d = 0; m_w = 0; m_h = 0;
    mdl_tc = '0;
    mdl_mc = '0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic t, input logic en, input logic clr,
                            input logic [31:0] d, input logic [31:0] w, input logic [31:0] h);
    bit acc;
    bit p;
    bit b;
    edge_n++;
    if (m_active && !en && edge_n >= m_c0 + 1) m_active = 1'b0;
    acc = t && en && (!m_active || edge_n >= m_c0 + m_d + m_w + m_h + 2);
    if (clr) begin
      mdl_tc = '0;
      mdl_mc = '0;
    end else begin
      if (acc) mdl_tc = mdl_tc + 32'd1;
      if (t && en && !acc && mdl_mc != 16'hFFFF) mdl_mc = mdl_mc + 16'd1;
    end
    if (acc) begin
      m_active = 1'b1;
      m_c0 = edge_n;
      m_d  = longint'(d);
      m_w  = (w == 0) ? 1 : longint'(w);
      m_h  = longint'(h);
    end
    p = m_active && edge_n >= m_c0 + m_d + 1 && edge_n <= m_c0 + m_d + m_w;
    b = m_active && edge_n >= m_c0 + 1 && edge_n <= m_c0 + m_d + m_w + m_h;
    exp_q.push_back({p, b, mdl_tc, mdl_mc});
  endtask

  // Driver: apply one cycle of inputs, advance one edge, compare against the model.
  task automatic step(input logic t, input logic en, input logic clr,
                      input logic [31:0] d, input logic [31:0] w, input logic [31:0] h);
    logic [49:0] e;
    trig = t; enable = en; clear = clr; delay = d; width = w; holdoff = h;
    model_edge(t, en, clr, d, w, h);
    @(posedge aclk);
    #1;
    e = exp_q.pop_front();
    chk("pulse_out", 32'(pulse_out), 32'(e[49]));
    chk("busy", 32'(busy), 32'(e[48]));
    chk("trig_count", trig_count, e[47:16]);
    chk("miss_count", 32'(miss_count), 32'(e[15:0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0);
  endtask

  task automatic async_reset();
    #2 aresetn = 1'b0;
    #1;
    chk("rst_pulse_now", 32'(pulse_out), 32'd0);
    chk("rst_busy_now", 32'(busy), 32'd0);
    chk("rst_tc_now", trig_count, 32'd0);
    chk("rst_mc_now", 32'(miss_count), 32'd0);
    model_reset();
    trig = 1'b0; clear = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  typedef struct {
    logic        t;
    logic [31:0] d, w, h;
    logic        p, b;
    logic [31:0] tc;
  } vec_t;

  vec_t vecs[18];

  task automatic set_vec(input int i, input logic t, input logic [31:0] d, input logic [31:0] w,
                         input logic [31:0] h, input logic p, input logic b, input logic [31:0] tc);
    vecs[i] = '{t: t, d: d, w: w, h: h, p: p, b: b, tc: tc};
  endtask

  initial begin
    aresetn = 1'b0;
    enable = 1'b0; trig = 1'b0; clear = 1'b0;
    delay = '0; width = '0; holdoff = '0;
    model_reset();

    // Basic pulse D=3 W=2 H=4, then minimum latency D=0 W=0 H=0.
    set_vec(0, 1, 3, 2, 4, 0, 0, 1);
    for (int i = 1; i < 4; i++) set_vec(i, 0, 3, 2, 4, 0, 1, 1);
    set_vec(4, 0, 3, 2, 4, 1, 1, 1);
    set_vec(5, 0, 3, 2, 4, 1, 1, 1);
    for (int i = 6; i < 10; i++) set_vec(i, 0, 3, 2, 4, 0, 1, 1);
    set_vec(10, 0, 3, 2, 4, 0, 0, 1);
    set_vec(11, 0, 3, 2, 4, 0, 0, 1);
    set_vec(12, 1, 0, 0, 0, 0, 0, 2);
    set_vec(13, 0, 0, 0, 0, 1, 1, 2);
    set_vec(14, 0, 0, 0, 0, 0, 0, 2);
    set_vec(15, 1, 0, 0, 0, 0, 0, 3);
    set_vec(16, 0, 0, 0, 0, 1, 1, 3);
    set_vec(17, 0, 0, 0, 0, 0, 0, 3);

    repeat (3) @(posedge aclk);
    #1;
    chk("reset_pulse", 32'(pulse_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tc", trig_count, 32'd0);
    chk("reset_mc", 32'(miss_count), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].t, 1'b1, 1'b0, vecs[i].d, vecs[i].w, vecs[i].h);
      chk("vec_pulse", 32'(pulse_out), 32'(vecs[i].p));
      chk("vec_busy", 32'(busy), 32'(vecs[i].b));
      chk("vec_tc", trig_count, vecs[i].tc);
      chk("vec_mc", 32'(miss_count), 32'd0);
    end

    // Retrigger boundary: trig at E5 and E10 missed, E11 accepted, second pulse at E15.
    step(1'b0, 1'b1, 1'b1, 32'd3, 32'd2, 32'd4);
    for (int k = 0; k <= 15; k++) begin
      step((k == 0 || k == 5 || k == 10 || k == 11), 1'b1, 1'b0, 32'd3, 32'd2, 32'd4);
      if (k == 14) chk("retrig_pulse_e14", 32'(pulse_out), 32'd0);
      if (k == 15) chk("retrig_pulse_e15", 32'(pulse_out), 32'd1);
    end
    chk("retrig_mc", 32'(miss_count), 32'd2);
    chk("retrig_tc", trig_count, 32'd2);
    idle(12);

    // Config change mid-sequence has no effect until the next acceptance.
    for (int k = 0; k <= 4; k++)
      step(k == 0, 1'b1, 1'b0, (k >= 2) ? 32'd10 : 32'd3, 32'd2, 32'd1);
    chk("cfg_pulse_e4", 32'(pulse_out), 32'd1);
    idle(6);
    for (int k = 0; k <= 11; k++) begin
      step(k == 0, 1'b1, 1'b0, 32'd10, 32'd2, 32'd1);
      if (k == 10) chk("cfg_d10_e10", 32'(pulse_out), 32'd0);
      if (k == 11) chk("cfg_d10_e11", 32'(pulse_out), 32'd1);
    end
    idle(4);

    // Abort with enable=0 during PULSE, then disabled triggers are ignored.
    for (int k = 0; k <= 4; k++) step(k == 0, 1'b1, 1'b0, 32'd3, 32'd2, 32'd4);
    step(1'b0, 1'b0, 1'b0, 32'd3, 32'd2, 32'd4);
    chk("abort_pulse", 32'(pulse_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0);
    idle(2);

    // Asynchronous reset mid-DELAY and mid-PULSE.
    step(1'b1, 1'b1, 1'b0, 32'd5, 32'd2, 32'd2);
    step(1'b0, 1'b1, 1'b0, 32'd5, 32'd2, 32'd2);
    async_reset();
    idle(2);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd5, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd5, 32'd0);
    async_reset();
    idle(2);

    // Miss counter saturation.
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd1, 32'd200000);
    for (int k = 0; k < 65540; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd1, 32'd200000);
    chk("miss_saturated", 32'(miss_count), 32'h0000FFFF);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0);
    idle(2);

    // trig_count wrap from a preloaded value.
    force dut.trig_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.trig_cnt_q;
    mdl_tc = 32'hFFFF_FFFE;
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0);
    chk("wrap_tc_max", trig_count, 32'hFFFF_FFFF);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd1, 32'd0);
    chk("wrap_tc_zero", trig_count, 32'd0);
    idle(3);

    // Clear coincident with an accepted trigger.
    step(1'b1, 1'b1, 1'b0, 32'd1, 32'd1, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd1, 32'd1, 32'd0);
    idle(4);
    step(1'b1, 1'b1, 1'b1, 32'd1, 32'd1, 32'd0);
    chk("clear_vs_accept_tc", trig_count, 32'd0);
    chk("clear_vs_accept_mc", 32'(miss_count), 32'd0);
    idle(4);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0,
           32'($urandom_range(0, 4)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 4)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
